entrada_saida_param: RTL and testbench

Parametrised memory-mapped I/O controller for the LabSO processor. It is the next generation of the existing entrada/saída path.
- Input: the CPU requests a read, the block stalls the CPU until a debounced button press, then returns the zero-extended switch value.
- Output: the CPU writes a word, which a sequential double-dabble engine converts into DIGITS BCD digits for the display.
- Sits between the datapath (address/data/control) and the board switches, button and 7-segment digits.

---
 rtl/entrada_saida_param_if.sv | 27 ++
 rtl/entrada_saida_param.sv | 180 ++++++++++++++++++
 tb/tb_entrada_saida_param.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/entrada_saida_param_if.sv
// CPU-side bus of the LabSO I/O controller: control, write data, read data,
// stall and completion pulse. master = datapath, slave = I/O controller.
interface entrada_saida_param_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        entradaSaidaControl;
    logic [DATA_W-1:0] dadosEscrita;
    logic [DATA_W-1:0] DadosLidos;
    logic              stall;
    logic              io_done;

    modport master (
        output entradaSaidaControl,
        output dadosEscrita,
        input  DadosLidos,
        input  stall,
        input  io_done
    );

    modport slave (
        input  entradaSaidaControl,
        input  dadosEscrita,
        output DadosLidos,
        output stall,
        output io_done
    );
endinterface

// File: rtl/entrada_saida_param.sv
// Memory-mapped I/O controller: debounced switch read and double-dabble
// display write. Ports: clk, reset (sync, active-high), bus (CPU side:
// entradaSaidaControl, dadosEscrita, DadosLidos, stall, io_done),
// entradaDeDados, botaoIN, digits, overflow. Define IO_SEG7_EN to add the
// active-low 7-segment output seg (a..g per digit, units in seg[6:0]).
module entrada_saida_param #(
    parameter int DATA_W          = 32,
    parameter int IN_W            = 4,
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    entrada_saida_param_if.slave    bus,
    input  logic [IN_W-1:0]         entradaDeDados,
    input  logic                    botaoIN,
    output logic [4*DIGITS-1:0]     digits,
    output logic                    overflow
`ifdef IO_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]     seg
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int SW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        IN_WAIT,
        OUT_CONV
    } state_t;

    state_t              state;
    logic                btn_s1, btn_s2;
    logic                btn_db, btn_db_q;
    logic [CW-1:0]       db_cnt;
    logic [IN_W-1:0]     sw_s1, sw_s2;
    logic [DATA_W-1:0]   shreg;
    logic [4*DIGITS-1:0] bcd;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] bcd_nx;
    logic                carry;
    logic                ovf_s;
    logic [SW-1:0]       step;
    logic                press;

    // Only a fresh debounced rising edge counts as a press.
    assign press = btn_db & ~btn_db_q;

    assign bus.stall = (state != IDLE) |
                       (bus.entradaSaidaControl == 2'b01) |
                       (bus.entradaSaidaControl == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
        end else begin
            btn_s1   <= botaoIN;
            btn_s2   <= btn_s1;
            sw_s1    <= entradaDeDados;
            sw_s2    <= sw_s1;
            btn_db_q <= btn_db;
            if (btn_s2 != btn_db) begin
                if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // One double-dabble step; the bit leaving the top nibble marks overflow.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {carry, bcd_nx} = {adj, shreg[DATA_W-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.DadosLidos <= '0;
            bus.io_done    <= 1'b0;
            digits         <= '0;
            overflow       <= 1'b0;
            shreg          <= '0;
            bcd            <= '0;
            ovf_s          <= 1'b0;
            step           <= '0;
        end else begin
            bus.io_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.entradaSaidaControl == 2'b10) begin
                        state <= IN_WAIT;
                    end else if (bus.entradaSaidaControl == 2'b01) begin
                        state <= OUT_CONV;
                        shreg <= bus.dadosEscrita;
                        bcd   <= '0;
                        ovf_s <= 1'b0;
                        step  <= SW'(DATA_W);
                    end
                end
                IN_WAIT: begin
                    if (press) begin
                        bus.DadosLidos <= DATA_W'(sw_s2);
                        bus.io_done    <= 1'b1;
                        state          <= IDLE;
                    end
                end
                OUT_CONV: begin
                    bcd   <= bcd_nx;
                    shreg <= shreg << 1;
                    ovf_s <= ovf_s | carry;
                    step  <= step - 1'b1;
                    if (step == SW'(1)) begin
                        digits      <= bcd_nx;
                        overflow    <= ovf_s | carry;
                        bus.io_done <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IO_SEG7_EN
    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic lead;

    // Scan from the top digit down; blank while still in leading zeros.
    always_comb begin
        lead = 1'b1;
        seg  = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (digits[4*i +: 4] != 4'd0)
                lead = 1'b0;
            if (overflow)
                seg[7*i +: 7] = 7'b1111110;
            else if (lead && i != 0)
                seg[7*i +: 7] = 7'b1111111;
            else
                seg[7*i +: 7] = seg_lut(digits[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_entrada_saida_param.sv
// Directed self-checking bench for entrada_saida_param
// (DATA_W=32, IN_W=4, DIGITS=3, DEBOUNCE_CYCLES=4).
module tb_entrada_saida_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sw = 4'd0;
    logic        btn = 1'b0;
    logic [11:0] digits;
    logic        overflow;
`ifdef IO_SEG7_EN
    logic [20:0] seg;
`endif

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    entrada_saida_param_if #(.DATA_W(32)) bus ();

    entrada_saida_param #(
        .DATA_W(32),
        .IN_W(4),
        .DIGITS(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .entradaDeDados(sw),
        .botaoIN(btn),
        .digits(digits),
        .overflow(overflow)
`ifdef IO_SEG7_EN
        ,
        .seg(seg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus.io_done === 1'b1)
            done_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic do_write(input string tag, input logic [31:0] v,
                            input logic [11:0] ed, input logic eo);
        int n;
        int io_idx;
        int dn;
        logic [11:0] old;
        n = 0;
        io_idx = -1;
        dn = 0;
        old = digits;
        bus.entradaSaidaControl = 2'b01;
        bus.dadosEscrita = v;
        #1;
        if (bus.stall === 1'b1)
            n++;
        for (int i = 1; i <= 40; i++) begin
            tick();
            bus.entradaSaidaControl = 2'b00;
            #1;
            if (bus.stall === 1'b1) begin
                n++;
                if (i == 16)
                    chk({tag, "_hold"}, digits, old);
            end
            if (bus.io_done === 1'b1) begin
                dn++;
                if (io_idx < 0)
                    io_idx = i;
            end
        end
        chk({tag, "_stall_cycles"}, n, 33);
        chk({tag, "_done_at"}, io_idx, 33);
        chk({tag, "_done_pulses"}, dn, 1);
        chk({tag, "_digits"}, digits, ed);
        chk({tag, "_ovf"}, overflow, eo);
    endtask

    initial begin
        bus.entradaSaidaControl = 2'b00;
        bus.dadosEscrita = 32'd0;
        @(negedge clk);

        // 1: reset, then reset in the middle of a conversion
        ticks(3);
        chk("rst_digits", digits, 12'h000);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_lidos", bus.DadosLidos, 32'd0);
        chk("rst_done", bus.io_done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        tick();
        bus.entradaSaidaControl = 2'b01;
        bus.dadosEscrita = 32'd123;
        tick();
        bus.entradaSaidaControl = 2'b00;
        ticks(5);
        chk("conv_busy", bus.stall, 1'b1);
        reset = 1'b1;
        tick();
        chk("abort_stall", bus.stall, 1'b0);
        ticks(2);
        reset = 1'b0;
        tick();
        chk("post_rst_digits", digits, 12'h000);
        chk("post_rst_stall", bus.stall, 1'b0);
        chk("post_rst_lidos", bus.DadosLidos, 32'd0);
        tick();
        chk("post_rst_idle", bus.stall, 1'b0);

        // 2, 3: conversions
        do_write("w255", 32'd255, 12'h255, 1'b0);
        do_write("w1234", 32'd1234, 12'h234, 1'b1);
`ifdef IO_SEG7_EN
        chk("seg_dash", seg, {7'b1111110, 7'b1111110, 7'b1111110});
`endif
        do_write("w7", 32'd7, 12'h007, 1'b0);
`ifdef IO_SEG7_EN
        chk("seg_7", seg, {7'b1111111, 7'b1111111, 7'b0001111});
`endif
        do_write("wmax", 32'hFFFF_FFFF, 12'h295, 1'b1);
        do_write("w999", 32'd999, 12'h999, 1'b0);
        do_write("w1000", 32'd1000, 12'h000, 1'b1);

        // 4: read with bouncing button
        sw = 4'b1010;
        bus.entradaSaidaControl = 2'b10;
        #1;
        chk("rd_stall_comb", bus.stall, 1'b1);
        tick();
        bus.entradaSaidaControl = 2'b00;
        done_cnt = 0;
        btn = 1'b1;
        ticks(2);
        btn = 1'b0;
        ticks(1);
        chk("bounce_no_press", done_cnt, 0);
        chk("bounce_stall", bus.stall, 1'b1);
        btn = 1'b1;
        ticks(15);
        chk("rd_pulses", done_cnt, 1);
        chk("rd_lidos", bus.DadosLidos, 32'h0000_000A);
        chk("rd_stall_clear", bus.stall, 1'b0);
        btn = 1'b0;
        ticks(10);

        // 5: press while idle, read while held
        sw = 4'b0101;
        done_cnt = 0;
        btn = 1'b1;
        ticks(10);
        chk("idle_press_lidos", bus.DadosLidos, 32'h0000_000A);
        bus.entradaSaidaControl = 2'b10;
        tick();
        bus.entradaSaidaControl = 2'b00;
        ticks(15);
        chk("held_wait", bus.stall, 1'b1);
        chk("held_no_done", done_cnt, 0);
        btn = 1'b0;
        ticks(10);
        chk("release_wait", bus.stall, 1'b1);
        btn = 1'b1;
        ticks(10);
        chk("repress_pulses", done_cnt, 1);
        chk("repress_lidos", bus.DadosLidos, 32'h0000_0005);
        chk("repress_stall", bus.stall, 1'b0);
        btn = 1'b0;
        ticks(10);

        // 6: read then write back-to-back, then ctrl=11
        sw = 4'b0011;
        bus.entradaSaidaControl = 2'b10;
        tick();
        bus.entradaSaidaControl = 2'b00;
        btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.io_done === 1'b1)
                break;
        end
        chk("b2b_rd_done", bus.io_done, 1'b1);
        chk("b2b_rd_lidos", bus.DadosLidos, 32'h0000_0003);
        bus.entradaSaidaControl = 2'b01;
        bus.dadosEscrita = 32'd42;
        #1;
        chk("b2b_wr_stall", bus.stall, 1'b1);
        tick();
        bus.entradaSaidaControl = 2'b00;
        #1;
        chk("b2b_conv", bus.stall, 1'b1);
        chk("b2b_conv_done", bus.io_done, 1'b0);
        ticks(31);
        chk("b2b_hold", digits, 12'h000);
        chk("b2b_busy", bus.stall, 1'b1);
        tick();
        chk("b2b_digits", digits, 12'h042);
        chk("b2b_done", bus.io_done, 1'b1);
        chk("b2b_stall_drop", bus.stall, 1'b0);
        btn = 1'b0;
        bus.entradaSaidaControl = 2'b11;
        #1;
        chk("nop_stall_comb", bus.stall, 1'b0);
        tick();
        chk("nop_stall", bus.stall, 1'b0);
        chk("nop_done", bus.io_done, 1'b0);
        bus.entradaSaidaControl = 2'b00;
        tick();
        chk("nop_digits", digits, 12'h042);
        chk("nop_ovf", overflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
